tap_imem_loader: RTL and testbench

- JTAG-side writer for the instruction-memory BRAM. Runs entirely in the TCK domain.
- Takes DR-shift controls from the TAP controller and shifts in an address or a data word via TDI.
- Generates the single-cycle write strobe, write address and write data for the BRAM's TCK write port.
- The address auto-increments, so a program image streams in as consecutive DR scans.

---
 rtl/tap_imem_loader.sv | 175 +++++++++++++++++
 tb/tb_tap_imem_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tap_imem_loader.sv
// JTAG-side loader for the instruction-memory BRAM. It runs entirely in the TCK domain, shifts in
// an address or a data word, and issues one-cycle writes with an auto-incrementing address.
// Optional running checksum of written words: define TAP_IMEM_CHKSUM_EN.
module tap_imem_loader #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned MEMDEPTH = 1024
) (
  input  logic              tck_i,
  input  logic              trst_ni,
  input  logic              sel_addr_i,
  input  logic              sel_data_i,
  input  logic              capture_dr_i,
  input  logic              shift_dr_i,
  input  logic              update_dr_i,
  input  logic              tdi_i,
  output logic              tdo_o,
  output logic [ADDR_W-1:0] loadAddr_o,
  output logic [DATA_W-1:0] loadData_o,
  output logic              wEn_o,
  output logic              overflow_o,
  output logic              err_o
`ifdef TAP_IMEM_CHKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum_o
`endif
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  logic [0:0]        r_state;
  logic [DATA_W-1:0] r_sr;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_load_addr;
  logic [DATA_W-1:0] r_load_data;
  logic              r_wen;
  logic              r_ovf;
  logic              r_err;

  logic [0:0]        w_state_nxt;
  logic [DATA_W-1:0] w_sr_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [ADDR_W-1:0] w_load_addr_nxt;
  logic [DATA_W-1:0] w_load_data_nxt;
  logic              w_wen_nxt;
  logic              w_ovf_nxt;
  logic              w_err_nxt;

  logic              w_dr_active;
  logic [DATA_W-1:0] w_cap_addr;
  logic [DATA_W-1:0] w_cap_data;

`ifdef TAP_IMEM_CHKSUM_EN
  logic [DATA_W-1:0] r_chk;
  logic [DATA_W-1:0] w_chk_nxt;
  assign w_cap_data = r_chk;
  assign checksum_o = r_chk;
`else
  assign w_cap_data = r_load_data;
`endif

  assign w_dr_active = sel_addr_i | sel_data_i;

  // Address-register readback word: status flags in the two top bits
  always_comb begin
    w_cap_addr             = '0;
    w_cap_addr[ADDR_W-1:0] = r_addr;
    w_cap_addr[DATA_W-1]   = r_ovf;
    w_cap_addr[DATA_W-2]   = r_err;
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_state     <= ST_IDLE;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_load_addr <= '0;
      r_load_data <= '0;
      r_wen       <= 1'b0;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
`ifdef TAP_IMEM_CHKSUM_EN
      r_chk       <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_sr        <= w_sr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_addr      <= w_addr_nxt;
      r_load_addr <= w_load_addr_nxt;
      r_load_data <= w_load_data_nxt;
      r_wen       <= w_wen_nxt;
      r_ovf       <= w_ovf_nxt;
      r_err       <= w_err_nxt;
`ifdef TAP_IMEM_CHKSUM_EN
      r_chk       <= w_chk_nxt;
`endif
    end
  end

  // Next state: capture > update > shift; sel_addr wins over sel_data
  always_comb begin
    w_state_nxt     = r_state;
    w_sr_nxt        = r_sr;
    w_cnt_nxt       = r_cnt;
    w_addr_nxt      = r_addr;
    w_load_addr_nxt = r_load_addr;
    w_load_data_nxt = r_load_data;
    w_wen_nxt       = 1'b0;
    w_ovf_nxt       = r_ovf;
    w_err_nxt       = r_err;
`ifdef TAP_IMEM_CHKSUM_EN
    w_chk_nxt       = r_chk;
`endif

    if (w_dr_active) begin
      if (capture_dr_i) begin
        w_sr_nxt  = sel_addr_i ? w_cap_addr : w_cap_data;
        w_cnt_nxt = '0;
      end else if (update_dr_i) begin
        // Updates landing while a write is in flight are dropped
        if (r_state == ST_IDLE) begin
          if (sel_addr_i) begin
            w_addr_nxt = r_sr[DATA_W-1 -: ADDR_W];
            w_ovf_nxt  = 1'b0;
            w_err_nxt  = 1'b0;
`ifdef TAP_IMEM_CHKSUM_EN
            w_chk_nxt  = '0;
`endif
          end else if (r_cnt < CNT_W'(DATA_W)) begin
            w_err_nxt = 1'b1;
          end else if (!r_ovf) begin
            w_state_nxt     = ST_WRITE;
            w_wen_nxt       = 1'b1;
            w_load_addr_nxt = r_addr;
            w_load_data_nxt = r_sr;
          end
        end
      end else if (shift_dr_i) begin
        w_sr_nxt = {tdi_i, r_sr[DATA_W-1:1]};
        if (r_cnt != CNT_W'(DATA_W)) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
    end

    // Leaving WRITE: advance the address, lock writes once it wraps
    if (r_state == ST_WRITE) begin
      w_state_nxt = ST_IDLE;
      if (r_addr == ADDR_W'(MEMDEPTH - 1)) begin
        w_addr_nxt = '0;
        w_ovf_nxt  = 1'b1;
      end else begin
        w_addr_nxt = r_addr + ADDR_W'(1);
      end
`ifdef TAP_IMEM_CHKSUM_EN
      w_chk_nxt = r_chk + r_load_data;
`endif
    end
  end

  assign tdo_o      = r_sr[0];
  assign loadAddr_o = r_load_addr;
  assign loadData_o = r_load_data;
  assign wEn_o      = r_wen;
  assign overflow_o = r_ovf;
  assign err_o      = r_err;

endmodule

// File: tb/tb_tap_imem_loader.sv
// Scoreboard bench for tap_imem_loader: expected writes are queued by the stimulus and
// checked by a monitor whenever wEn_o is seen high.
module tb_tap_imem_loader;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 10;

  logic              tck = 1'b0;
  logic              trst_ni = 1'b0;
  logic              sel_addr = 1'b0;
  logic              sel_data = 1'b0;
  logic              capture = 1'b0;
  logic              shift = 1'b0;
  logic              update = 1'b0;
  logic              tdi = 1'b0;
  logic              tdo;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              wen;
  logic              ovf;
  logic              err;
`ifdef TAP_IMEM_CHKSUM_EN
  logic [DATA_W-1:0] chksum;
`endif

  tap_imem_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEMDEPTH(1024)) dut (
    .tck_i       (tck),
    .trst_ni     (trst_ni),
    .sel_addr_i  (sel_addr),
    .sel_data_i  (sel_data),
    .capture_dr_i(capture),
    .shift_dr_i  (shift),
    .update_dr_i (update),
    .tdi_i       (tdi),
    .tdo_o       (tdo),
    .loadAddr_o  (load_addr),
    .loadData_o  (load_data),
    .wEn_o       (wen),
    .overflow_o  (ovf),
    .err_o       (err)
`ifdef TAP_IMEM_CHKSUM_EN
    ,
    .checksum_o  (chksum)
`endif
  );

  always #5 tck = ~tck;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;

  always @(posedge tck) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every wEn_o sample must match the oldest queued write, including its cycle
  always @(negedge tck) begin
    if (wen === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_wen", 32'(wen), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_addr", 32'(load_addr), 32'(e.addr));
        chk("wr_data", load_data, e.data);
        chk("wr_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge tck);
    #1;
  endtask

  // Capture, shift nbits of val LSB-first (collecting tdo), optional update, then 2 idle cycles
  task automatic scan(input logic sa, input logic sd, input logic [31:0] val, input int nbits,
                      input logic do_upd, input logic exp_wr, input logic [ADDR_W-1:0] exp_addr,
                      output logic [31:0] rb);
    sel_addr = sa;
    sel_data = sd;
    capture  = 1'b1;
    step();
    capture = 1'b0;
    rb = '0;
    for (int i = 0; i < nbits; i++) begin
      shift = 1'b1;
      tdi   = val[i];
      rb[i] = tdo;
      step();
    end
    shift = 1'b0;
    tdi   = 1'b0;
    if (do_upd) begin
      update = 1'b1;
      if (exp_wr) q.push_back('{exp_addr, val, cyc + 1});
      step();
      update = 1'b0;
    end
    sel_addr = 1'b0;
    sel_data = 1'b0;
    step();
    step();
  endtask

  task automatic addr_scan(input logic [ADDR_W-1:0] a);
    logic [31:0] rb;
    scan(1'b1, 1'b0, 32'(a), ADDR_W, 1'b1, 1'b0, '0, rb);
  endtask

  task automatic data_scan(input logic [31:0] d, input logic exp_wr, input logic [ADDR_W-1:0] a);
    logic [31:0] rb;
    scan(1'b0, 1'b1, d, 32, 1'b1, exp_wr, a, rb);
  endtask

  task automatic readback(input logic sa, output logic [31:0] rb);
    scan(sa, ~sa, 32'd0, 32, 1'b0, 1'b0, '0, rb);
  endtask

  initial begin
    logic [31:0] rb;
    repeat (2) @(posedge tck);
    #1;
    trst_ni = 1'b1;
    step();
    chk("rst_wen", 32'(wen), 32'd0);
    chk("rst_addr", 32'(load_addr), 32'd0);
    chk("rst_data", load_data, 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_tdo", 32'(tdo), 32'd0);

    // Single write and address auto-increment readback
    addr_scan(10'h010);
    data_scan(32'hDEADBEEF, 1'b1, 10'h010);
    readback(1'b1, rb);
    chk("rb_addr_011", rb, 32'h0000_0011);

    // Streaming three words from address 0
    addr_scan(10'h000);
    data_scan(32'h1, 1'b1, 10'h000);
    data_scan(32'h2, 1'b1, 10'h001);
    data_scan(32'h3, 1'b1, 10'h002);
    chk("hold_addr", 32'(load_addr), 32'h2);
    chk("hold_data", load_data, 32'h3);
    readback(1'b1, rb);
    chk("rb_addr_3", rb, 32'h0000_0003);

    // Wrap at the last word sets overflow and locks further writes
    addr_scan(10'h3FF);
    data_scan(32'hA5A5A5A5, 1'b1, 10'h3FF);
    chk("ovf_set", 32'(ovf), 32'd1);
    data_scan(32'h5A5A5A5A, 1'b0, '0);
    readback(1'b1, rb);
    chk("rb_ovf_bit", rb, 32'h8000_0000);
    addr_scan(10'h000);
    chk("ovf_clr", 32'(ovf), 32'd0);

    // Short data shift raises err and writes nothing
    scan(1'b0, 1'b1, 32'hFFFFF, 20, 1'b1, 1'b0, '0, rb);
    chk("err_set", 32'(err), 32'd1);
    readback(1'b1, rb);
    chk("rb_err_bit", rb, 32'h4000_0000);
    readback(1'b0, rb);
`ifdef TAP_IMEM_CHKSUM_EN
    chk("rb_data", rb, 32'h0000_0000);
`else
    chk("rb_data", rb, 32'hA5A5A5A5);
`endif

    // Both selects high: address register wins, err clears
    scan(1'b1, 1'b1, 32'h020, ADDR_W, 1'b1, 1'b0, '0, rb);
    chk("both_sel_err", 32'(err), 32'd0);
    readback(1'b1, rb);
    chk("rb_addr_020", rb, 32'h0000_0020);

    // Reset asserted during the WRITE cycle
    addr_scan(10'h040);
    scan(1'b0, 1'b1, 32'h12345678, 32, 1'b0, 1'b0, '0, rb);
    sel_data = 1'b1;
    update   = 1'b1;
    step();
    chk("wen_in_write", 32'(wen), 32'd1);
    trst_ni = 1'b0;
    #1;
    chk("midrst_wen", 32'(wen), 32'd0);
    chk("midrst_addr", 32'(load_addr), 32'd0);
    chk("midrst_data", load_data, 32'd0);
    chk("midrst_flags", {30'd0, ovf, err}, 32'd0);
    update   = 1'b0;
    sel_data = 1'b0;
    step();
    trst_ni = 1'b1;
    step();
    readback(1'b1, rb);
    chk("rb_addr_after_rst", rb, 32'h0000_0000);

`ifdef TAP_IMEM_CHKSUM_EN
    addr_scan(10'h000);
    data_scan(32'hFFFFFFFF, 1'b1, 10'h000);
    data_scan(32'h00000002, 1'b1, 10'h001);
    chk("chksum", chksum, 32'h0000_0001);
    readback(1'b0, rb);
    chk("rb_chksum", rb, 32'h0000_0001);
`endif

    repeat (3) step();
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
